// File: rtl/prio_arb_n_pkg.sv
// Shared types and helpers for the N-input priority arbiter.
package prio_arb_n_pkg;

    // Arbiter control states: nothing presented / grant presented.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width for an N-entry vector; a single requester still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder, highest set index wins.
module prio_enc_n
    import prio_arb_n_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_n.sv
// Registered N-input arbiter: fixed-priority or round-robin selection,
// grant held under a valid/ready handshake, outputs straight from registers.
module prio_arb_n
    import prio_arb_n_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    arb_state_e   r_state;
    arb_state_e   w_state_nxt;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;

    logic         w_accept;
    logic [W-1:0] w_ptr_eff;
    logic [N-1:0] w_mask;
    logic [W-1:0] w_mask_idx;
    logic         w_mask_any;
    logic [W-1:0] w_full_idx;
    logic         w_full_any;
    logic [W-1:0] w_win_idx;
    logic [N-1:0] w_win_onehot;
    logic         w_load;
    logic         w_clear;

    assign w_accept = (r_state == ST_GRANT) && out_ready;

    // A back-to-back arbitration must see the pointer as updated by this accept,
    // so the mask uses the index being accepted instead of the stale register.
    assign w_ptr_eff = w_accept ? r_idx : r_ptr;

    // Round-robin mask: keep only requesters strictly below the pointer.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_mask[i] = req[i] && (W'(i) < w_ptr_eff);
        end
    end

    prio_enc_n #(.N(N)) u_enc_mask (
        .req (w_mask),
        .idx (w_mask_idx),
        .any (w_mask_any)
    );

    prio_enc_n #(.N(N)) u_enc_full (
        .req (req),
        .idx (w_full_idx),
        .any (w_full_any)
    );

    assign w_win_idx    = (rr_mode && w_mask_any) ? w_mask_idx : w_full_idx;
    assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and output-register load/clear strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_full_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (out_ready) begin
                    if (w_full_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant registers: capture a new winner, or blank the one-hot when going idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_onehot <= '0;
        end else if (w_load) begin
            r_idx    <= w_win_idx;
            r_onehot <= w_win_onehot;
        end else if (w_clear) begin
            r_onehot <= '0;
        end
    end

    // Round-robin pointer: remembers the last accepted index in either mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= r_idx;
        end
    end

    assign out_valid  = (r_state == ST_GRANT);
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;

endmodule
